// File: rtl/adder_result_fifo.sv
// Result buffer behind adder_16bit: a DEPTH-entry FIFO of {overflow, cout, sum}
// with valid/ready on both sides, plus sticky and saturating overflow statistics.
module adder_result_fifo #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both 1; ready never depends on the same-side valid, valid never on ready.
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [15:0]              in_sum,
  input  logic                     in_cout,
  input  logic                     in_overflow,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [15:0]              out_sum,
  output logic                     out_cout,
  output logic                     out_overflow,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf_sticky,
  output logic [CNT_W-1:0]         ovf_count,
  input  logic                     clr_stats
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [OCC_W-1:0] OCC_ONE = OCC_W'(1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
  localparam logic [CNT_W-1:0] STAT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] STAT_MAX = '1;

  logic [17:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] count_q, count_d;
  logic             ovf_sticky_q, ovf_sticky_d;
  logic [CNT_W-1:0] ovf_count_q, ovf_count_d;

  logic        push;
  logic        pop;
  logic [17:0] head;

  assign in_ready  = (count_q != OCC_FULL);
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Outputs read registered storage only, so there is no same-cycle path from in_* to out_*.
  assign head = mem_q[rd_ptr_q];
  assign {out_overflow, out_cout, out_sum} = out_valid ? head : 18'd0;

  assign count      = count_q;
  assign ovf_sticky = ovf_sticky_q;
  assign ovf_count  = ovf_count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push, pop})
      2'b10:   count_d = count_q + OCC_ONE;
      2'b01:   count_d = count_q - OCC_ONE;
      default: count_d = count_q;
    endcase
  end

  // A clear applied with an overflow push keeps that push's contribution.
  always_comb begin
    ovf_sticky_d = ovf_sticky_q;
    ovf_count_d  = ovf_count_q;
    if (clr_stats) begin
      ovf_sticky_d = 1'b0;
      ovf_count_d  = '0;
    end
    if (push && in_overflow) begin
      ovf_sticky_d = 1'b1;
      if (ovf_count_d != STAT_MAX) ovf_count_d = ovf_count_d + STAT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      ovf_sticky_q <= 1'b0;
      ovf_count_q  <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      ovf_sticky_q <= ovf_sticky_d;
      ovf_count_q  <= ovf_count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_overflow, in_cout, in_sum};
  end

endmodule

// File: tb/tb_adder_result_fifo.sv
// Bench for adder_result_fifo: directed scenarios plus a random phase, checked
// against a queue-based model of the FIFO contents and overflow statistics.
module tb_adder_result_fifo;

  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic [15:0]            in_sum = '0;
  logic                   in_cout = 1'b0;
  logic                   in_overflow = 1'b0;
  logic                   out_valid;
  logic                   out_ready = 1'b0;
  logic [15:0]            out_sum;
  logic                   out_cout;
  logic                   out_overflow;
  logic [$clog2(DEPTH):0] count;
  logic                   ovf_sticky;
  logic [CNT_W-1:0]       ovf_count;
  logic                   clr_stats = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [17:0] exp_q[$];
  logic        exp_sticky = 1'b0;
  int          exp_cnt    = 0;

  adder_result_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_sum       (in_sum),
    .in_cout      (in_cout),
    .in_overflow  (in_overflow),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sum      (out_sum),
    .out_cout     (out_cout),
    .out_overflow (out_overflow),
    .count        (count),
    .ovf_sticky   (ovf_sticky),
    .ovf_count    (ovf_count),
    .clr_stats    (clr_stats)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // What adder_16bit would produce: {overflow, cout, sum}
  function automatic logic [17:0] add_res(input logic [15:0] a, input logic [15:0] b, input logic cin);
    logic [16:0] full;
    logic        ovf;
    full = {1'b0, a} + {1'b0, b} + {16'd0, cin};
    ovf  = (a[15] == b[15]) && (full[15] != a[15]);
    return {ovf, full[16], full[15:0]};
  endfunction

  // driver: inputs change 1 time unit after the rising edge
  task automatic drive(input logic v, input logic [17:0] e, input logic ordy, input logic clr);
    @(posedge clk);
    #1;
    in_valid  = v;
    {in_overflow, in_cout, in_sum} = v ? e : 18'($urandom);
    out_ready = ordy;
    clr_stats = clr;
  endtask

  task automatic idle(input logic ordy);
    drive(1'b0, 18'd0, ordy, 1'b0);
  endtask

  // scoreboard/monitor: compares at the falling edge, then applies this cycle's transfers
  always @(negedge clk) begin
    int  occ;
    logic m_push, m_pop;
    occ = exp_q.size();
    if (rst) begin
      exp_q.delete();
      exp_sticky = 1'b0;
      exp_cnt    = 0;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
    end else begin
      chk("count", 32'(count), 32'(occ));
      chk("out_valid", 32'(out_valid), 32'(occ != 0));
      chk("in_ready", 32'(in_ready), 32'(occ != DEPTH));
      chk("ovf_sticky", 32'(ovf_sticky), 32'(exp_sticky));
      chk("ovf_count", 32'(ovf_count), 32'(exp_cnt));
      if (occ != 0) chk("head_data", 32'({out_overflow, out_cout, out_sum}), 32'(exp_q[0]));
      else          chk("empty_data", 32'({out_overflow, out_cout, out_sum}), 32'd0);
      m_pop  = (occ != 0) && out_ready;
      m_push = in_valid && (occ != DEPTH);
      if (m_pop)  void'(exp_q.pop_front());
      if (m_push) exp_q.push_back({in_overflow, in_cout, in_sum});
      if (clr_stats) begin
        exp_sticky = 1'b0;
        exp_cnt    = 0;
      end
      if (m_push && in_overflow) begin
        exp_sticky = 1'b1;
        if (exp_cnt < CMAX) exp_cnt++;
      end
    end
  end

  initial begin
    logic [17:0] e;
    logic [17:0] first_after_rst;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // single result held until accepted
    e = add_res(16'hFFFF, 16'hFFFF, 1'b1);
    drive(1'b1, e, 1'b0, 1'b0);
    idle(1'b0);
    chk("t1_sum", 32'(out_sum), 32'hFFFF);
    chk("t1_cout", 32'(out_cout), 32'd1);
    chk("t1_count", 32'(count), 32'd1);
    chk("t1_sticky", 32'(ovf_sticky), 32'd0);
    idle(1'b0);
    idle(1'b0);
    chk("t1_hold_sum", 32'(out_sum), 32'hFFFF);
    idle(1'b1);
    idle(1'b0);
    chk("t1_drained_count", 32'(count), 32'd0);
    chk("t1_drained_sum", 32'(out_sum), 32'd0);

    // fill past full, then pop on a full cycle with in_valid high
    for (int i = 0; i < 5; i++)
      drive(1'b1, add_res(16'(i * 16'h1111), 16'h0101, 1'b0), 1'b0, 1'b0);
    idle(1'b0);
    chk("t2_full_count", 32'(count), 32'd4);
    chk("t2_full_in_ready", 32'(in_ready), 32'd0);
    drive(1'b1, add_res(16'h1234, 16'h4321, 1'b0), 1'b1, 1'b0);
    idle(1'b0);
    chk("t3_count", 32'(count), 32'd3);
    chk("t3_in_ready", 32'(in_ready), 32'd1);
    repeat (5) idle(1'b1);

    // overflow statistics
    drive(1'b1, add_res(16'h8000, 16'h8000, 1'b0), 1'b1, 1'b0);
    drive(1'b1, add_res(16'h7FFF, 16'h0001, 1'b0), 1'b1, 1'b0);
    drive(1'b1, add_res(16'h0000, 16'h0000, 1'b0), 1'b1, 1'b0);
    idle(1'b1);
    chk("t4_sticky", 32'(ovf_sticky), 32'd1);
    chk("t4_count", 32'(ovf_count), 32'd2);

    // saturation, then clear coinciding with an overflow push
    for (int i = 0; i < 300; i++)
      drive(1'b1, add_res(16'h4000 + 16'($urandom_range(0, 16'h3FFF)), 16'h4000, 1'b0), 1'b1, 1'b0);
    idle(1'b1);
    chk("t5_saturated", 32'(ovf_count), 32'(CMAX));
    drive(1'b1, add_res(16'h8000, 16'hFFFF, 1'b0), 1'b1, 1'b1);
    idle(1'b1);
    chk("t5_clr_push_count", 32'(ovf_count), 32'd1);
    chk("t5_clr_push_sticky", 32'(ovf_sticky), 32'd1);
    idle(1'b1);

    // asynchronous reset with entries buffered
    for (int i = 0; i < 3; i++)
      drive(1'b1, add_res(16'($urandom), 16'($urandom), 1'($urandom)), 1'b0, 1'b0);
    idle(1'b0);
    chk("t6_pre_count", 32'(count), 32'd3);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_valid", 32'(out_valid), 32'd0);
    chk("t6_async_count", 32'(count), 32'd0);
    chk("t6_async_sticky", 32'(ovf_sticky), 32'd0);
    chk("t6_async_ovfcnt", 32'(ovf_count), 32'd0);
    first_after_rst = add_res(16'h0BAD, 16'h0001, 1'b1);
    drive(1'b1, first_after_rst, 1'b0, 1'b0);
    rst = 1'b0;
    idle(1'b0);
    chk("t6_first_after_rst", 32'({out_overflow, out_cout, out_sum}), 32'(first_after_rst));
    chk("t6_count", 32'(count), 32'd1);
    idle(1'b1);

    // random traffic
    for (int i = 0; i < 400; i++)
      drive($urandom_range(0, 9) < 7, add_res(16'($urandom), 16'($urandom), 1'($urandom)),
            $urandom_range(0, 9) < 6, $urandom_range(0, 49) == 0);
    repeat (DEPTH + 2) idle(1'b1);
    chk("final_empty", 32'(count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
